// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated-count frequency meter.
package freq_meter_pkg;

   localparam int unsigned CNT_W_DEF = 32;
   localparam int unsigned SAT_W     = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GATE  = 2'd1,
      ST_DELAY = 2'd2
   } state_e;

   // Increment v by en, clamping at the all-ones value of a w-bit counter (1 <= w <= SAT_W).
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                input logic              en,
                                                input int unsigned       w);
      logic [SAT_W-1:0] max_v;
      max_v = {SAT_W{1'b1}} >> (SAT_W - w);
      if (en && (v != max_v)) begin
         return v + SAT_W'(1);
      end
      return v;
   endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge pulse detector.
module edge_sync_detect
   import freq_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sig,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/freq_gate_controller.sv
// Gate/latch/hold sequencer: counts sig_in rising edges over freq_base clocks, then
// presents the count on freq with freq_en high for time_del clocks.
module freq_gate_controller
   import freq_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic             sig_in,
   input  logic             run,
   input  logic [CNT_W-1:0] freq_base,
   input  logic [CNT_W-1:0] time_del,
   output logic [CNT_W-1:0] freq,
   output logic             freq_en,
   output logic             busy,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           r_state, w_state_d;
   logic [CNT_W-1:0] r_gate_cnt, w_gate_cnt_d;
   logic [CNT_W-1:0] r_del_cnt, w_del_cnt_d;
   logic [CNT_W-1:0] r_del_q, w_del_q_d;
   logic [CNT_W-1:0] r_edge_cnt, w_edge_cnt_d;
   logic [CNT_W-1:0] r_freq, w_freq_d;
   logic             r_overflow, w_overflow_d;
   logic             r_freq_en, r_busy;

   logic             w_rise;
   logic             w_load;
   logic             w_base_ok;
   logic [CNT_W-1:0] w_edge_next;

   edge_sync_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .i_clk (clk_clk),
      .i_rst (reset_reset),
      .i_sig (sig_in),
      .o_rise(w_rise)
   );

   assign w_base_ok   = (freq_base != '0);
   assign w_edge_next = CNT_W'(sat_inc(SAT_W'(r_edge_cnt), w_rise, CNT_W));

   always_comb begin
      w_state_d    = r_state;
      w_gate_cnt_d = r_gate_cnt;
      w_del_cnt_d  = r_del_cnt;
      w_del_q_d    = r_del_q;
      w_edge_cnt_d = r_edge_cnt;
      w_freq_d     = r_freq;
      w_overflow_d = r_overflow;
      w_load       = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (run && w_base_ok) begin
               w_load = 1'b1;
            end
         end
         ST_GATE: begin
            if (!run) begin
               w_state_d = ST_IDLE;
            end else if (r_gate_cnt == CNT_ONE) begin
               w_freq_d     = w_edge_next;
               // A count at the ceiling may have been clipped, so it is flagged.
               w_overflow_d = (w_edge_next == CNT_MAX);
               w_del_cnt_d  = (r_del_q == '0) ? CNT_ONE : r_del_q;
               w_state_d    = ST_DELAY;
            end else begin
               w_gate_cnt_d = r_gate_cnt - CNT_ONE;
               w_edge_cnt_d = w_edge_next;
            end
         end
         ST_DELAY: begin
            if (r_del_cnt == CNT_ONE) begin
               if (run && w_base_ok) begin
                  w_load = 1'b1;
               end else begin
                  w_state_d = ST_IDLE;
               end
            end else begin
               w_del_cnt_d = r_del_cnt - CNT_ONE;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase

      // Shadow the timing inputs so mid-measurement changes wait for the next gate.
      if (w_load) begin
         w_state_d    = ST_GATE;
         w_gate_cnt_d = freq_base;
         w_del_q_d    = time_del;
         w_edge_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state    <= ST_IDLE;
         r_gate_cnt <= '0;
         r_del_cnt  <= '0;
         r_del_q    <= '0;
         r_edge_cnt <= '0;
         r_freq     <= '0;
         r_overflow <= 1'b0;
         r_freq_en  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_gate_cnt <= w_gate_cnt_d;
         r_del_cnt  <= w_del_cnt_d;
         r_del_q    <= w_del_q_d;
         r_edge_cnt <= w_edge_cnt_d;
         r_freq     <= w_freq_d;
         r_overflow <= w_overflow_d;
         r_freq_en  <= (w_state_d == ST_DELAY);
         r_busy     <= (w_state_d == ST_GATE);
      end
   end

   assign freq     = r_freq;
   assign freq_en  = r_freq_en;
   assign busy     = r_busy;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_freq_gate_controller.sv
// Self-checking bench: vector table, hand-timed corner sequences and a result scoreboard.
module tb_freq_gate_controller;

   typedef struct {
      int unsigned base;
      int unsigned del;
      int unsigned hp;
      int unsigned exp;
      int unsigned tol;
   } vec_t;

   typedef struct {
      logic [31:0] exp;
      int unsigned tol;
      logic        ov;
   } sb_t;

   logic        clk, rst;
   logic        sig_in, run;
   logic [31:0] freq_base, time_del, freq;
   logic        freq_en, busy, overflow;

   // Width-1 instance: its counter ceiling is reachable, exercising the overflow flag.
   logic        s_sig, s_run;
   logic [0:0]  s_base, s_del, s_freq;
   logic        s_en, s_busy, s_ov;

   int          n_checks = 0;
   int          n_fail   = 0;
   sb_t         sb_q[$];
   int          last_busy_len = 0;
   int          last_en_len   = 0;

   int          hp       = 0;
   logic        sig_lvl  = 1'b0;
   logic        async_en = 1'b0;

   freq_gate_controller #(
      .CNT_W      (32),
      .SYNC_STAGES(2)
   ) u_dut (
      .clk_clk    (clk),
      .reset_reset(rst),
      .sig_in     (sig_in),
      .run        (run),
      .freq_base  (freq_base),
      .time_del   (time_del),
      .freq       (freq),
      .freq_en    (freq_en),
      .busy       (busy),
      .overflow   (overflow)
   );

   freq_gate_controller #(
      .CNT_W      (1),
      .SYNC_STAGES(2)
   ) u_sat (
      .clk_clk    (clk),
      .reset_reset(rst),
      .sig_in     (s_sig),
      .run        (s_run),
      .freq_base  (s_base),
      .time_del   (s_del),
      .freq       (s_freq),
      .freq_en    (s_en),
      .busy       (s_busy),
      .overflow   (s_ov)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_tol(input string name, input logic [63:0] act, input logic [63:0] exp,
                            input int unsigned tol);
      n_checks++;
      if ($isunknown(act) || (act + 64'(tol) < exp) || (act > exp + 64'(tol))) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   function automatic logic cur(input int which);
      case (which)
         0:       return busy;
         1:       return freq_en;
         default: return !busy && !freq_en;
      endcase
   endfunction

   task automatic wait_cond(input string name, input int which, input logic val, input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i <= budget; i++) begin
         if (cur(which) === val) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s: timeout after %0d cycles waiting for %0b", name, budget, val);
      end
   endtask

   // Stimulus source: async square wave (37-unit period), sync toggle every hp clocks, or sig_lvl.
   initial begin
      int   ph;
      logic in_async;
      ph       = 0;
      in_async = 1'b0;
      sig_in   = 1'b0;
      forever begin
         if (async_en) begin
            if (!in_async) begin
               in_async = 1'b1;
               #($urandom_range(0, 36));
            end
            #18 sig_in = 1'b1;
            #19 sig_in = 1'b0;
         end else begin
            in_async = 1'b0;
            @(posedge clk);
            #3;
            if (hp == 0) begin
               ph     = 0;
               sig_in = sig_lvl;
            end else begin
               ph++;
               if (ph >= hp) begin
                  ph     = 0;
                  sig_in = ~sig_in;
               end
            end
         end
      end
   end

   // Monitor: phase lengths and scoreboard pop on each fresh result.
   initial begin
      logic pb, pe;
      int   busy_len, en_len;
      sb_t  e;
      pb       = 1'b0;
      pe       = 1'b0;
      busy_len = 0;
      en_len   = 0;
      forever begin
         @(posedge clk);
         #2;
         if (busy) busy_len++;
         else if (pb) begin
            last_busy_len = busy_len;
            busy_len      = 0;
         end
         if (freq_en) en_len++;
         else if (pe) begin
            last_en_len = en_len;
            en_len      = 0;
         end
         if (freq_en && !pe) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: got result %0d, expected none", freq);
            end else begin
               e = sb_q.pop_front();
               check_tol("sb_freq", 64'(freq), 64'(e.exp), e.tol);
               check("sb_overflow", 64'(overflow), 64'(e.ov));
            end
         end
         pb = busy;
         pe = freq_en;
      end
   end

   task automatic single_gate(input string name, input int unsigned base, input int sig_at,
                              input int unsigned exp);
      run     = 1'b0;
      hp      = 0;
      sig_lvl = 1'b0;
      wait_cond("sg_idle", 2, 1'b1, 3000);
      repeat (6) tick();
      freq_base = base;
      time_del  = 3;
      sb_q.push_back('{exp, 0, 1'b0});
      if (sig_at < 0) begin
         sig_lvl = 1'b1;
         repeat (-sig_at) tick();
         run = 1'b1;
      end else begin
         run = 1'b1;
         repeat (sig_at) tick();
         sig_lvl = 1'b1;
      end
      wait_cond(name, 1, 1'b1, int'(base) + 20);
      run     = 1'b0;
      sig_lvl = 1'b0;
      wait_cond("sg_end", 2, 1'b1, 50);
   endtask

   initial begin
      vec_t vecs[4];
      int   viol;

      vecs[0] = '{1000, 200, 5, 100, 1};
      vecs[1] = '{100, 0, 1, 50, 1};
      vecs[2] = '{64, 10, 2, 16, 1};
      vecs[3] = '{30, 7, 3, 5, 1};

      rst       = 1'b1;
      run       = 1'b0;
      freq_base = '0;
      time_del  = '0;
      s_run     = 1'b0;
      s_sig     = 1'b0;
      s_base    = 1'b1;
      s_del     = 1'b1;
      tick();
      check("rst_freq", 64'(freq), 0);
      check("rst_freq_en", 64'(freq_en), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_overflow", 64'(overflow), 0);
      check("rst_sat_freq", 64'(s_freq), 0);
      rst = 1'b0;
      repeat (3) tick();

      for (int v = 0; v < 4; v++) begin
         run = 1'b0;
         wait_cond("vec_idle", 2, 1'b1, 3000);
         freq_base = vecs[v].base;
         time_del  = vecs[v].del;
         hp        = int'(vecs[v].hp);
         repeat (6) tick();
         sb_q.push_back('{vecs[v].exp, vecs[v].tol, 1'b0});
         run = 1'b1;
         wait_cond("vec_gate", 1, 1'b1, int'(vecs[v].base) + 20);
         wait_cond("vec_delay", 1, 1'b0, int'(vecs[v].del) + 20);
         #2;
         check("vec_gate_len", 64'(last_busy_len), 64'(vecs[v].base));
         check("vec_delay_len", 64'(last_en_len), (vecs[v].del == 0) ? 64'd1 : 64'(vecs[v].del));
         check("vec_regate", 64'(busy), 1);
         run = 1'b0;
      end

      wait_cond("base0_pre", 2, 1'b1, 3000);
      freq_base = '0;
      time_del  = 5;
      run       = 1'b1;
      viol      = 0;
      repeat (50) begin
         tick();
         if (busy || freq_en) viol++;
      end
      check("base0_stays_idle", 64'(viol), 0);
      run = 1'b0;

      single_gate("last_cycle_rise", 10, 8, 1);
      single_gate("first_delay_rise", 10, 9, 0);
      single_gate("pre_gate_rise", 10, -2, 0);
      single_gate("first_cycle_rise", 10, -1, 1);

      // Abort at gate cycle 500: result from the previous gate (1) must survive.
      freq_base = 1000;
      time_del  = 50;
      hp        = 5;
      repeat (4) tick();
      run = 1'b1;
      wait_cond("abort_start", 0, 1'b1, 20);
      repeat (499) tick();
      run = 1'b0;
      tick();
      check("abort_busy", 64'(busy), 0);
      check("abort_freq_en", 64'(freq_en), 0);
      check("abort_freq_kept", 64'(freq), 1);
      repeat (20) tick();
      check("abort_still_idle", 64'(busy), 0);
      check("abort_freq_still", 64'(freq), 1);

      freq_base = 1000;
      time_del  = 10;
      wait_cond("cfg_idle", 2, 1'b1, 100);
      repeat (4) tick();
      sb_q.push_back('{100, 1, 1'b0});
      sb_q.push_back('{50, 1, 1'b0});
      run = 1'b1;
      wait_cond("cfg_start", 0, 1'b1, 20);
      repeat (300) tick();
      freq_base = 500;
      wait_cond("cfg_gate1_end", 0, 1'b0, 1000);
      #2;
      check("cfg_gate1_len", 64'(last_busy_len), 1000);
      wait_cond("cfg_gate2_start", 0, 1'b1, 30);
      wait_cond("cfg_gate2_end", 0, 1'b0, 600);
      #2;
      check("cfg_gate2_len", 64'(last_busy_len), 500);
      run = 1'b0;
      wait_cond("cfg_end", 2, 1'b1, 100);

      // Width-1 counter: one edge fills it (overflow), the following empty gate clears it.
      repeat (4) tick();
      s_sig = 1'b1;
      tick();
      s_run = 1'b1;
      tick();
      check("sat_busy", 64'(s_busy), 1);
      tick();
      check("sat_en", 64'(s_en), 1);
      check("sat_freq", 64'(s_freq), 1);
      check("sat_overflow", 64'(s_ov), 1);
      tick();
      check("sat_regate", 64'(s_busy), 1);
      check("sat_delay_len1", 64'(s_en), 0);
      tick();
      check("sat2_freq", 64'(s_freq), 0);
      check("sat2_overflow", 64'(s_ov), 0);
      s_run = 1'b0;
      repeat (4) tick();
      check("sat_idle", 64'(s_busy | s_en), 0);

      // Asynchronous 3.7-clock signal over ten 370-cycle gates: 100 edges ideal each.
      freq_base = 370;
      time_del  = 20;
      async_en  = 1'b1;
      repeat (10) tick();
      for (int g = 0; g < 10; g++) sb_q.push_back('{100, 1, 1'b0});
      run = 1'b1;
      for (int g = 0; g < 10; g++) begin
         wait_cond("async_result", 1, 1'b1, 500);
         if (g == 9) run = 1'b0;
         wait_cond("async_delay", 1, 1'b0, 40);
      end
      wait_cond("async_end", 2, 1'b1, 500);
      check("sb_drained", 64'(sb_q.size()), 0);

      // Asynchronous reset in the middle of a gate with edges arriving.
      run = 1'b1;
      wait_cond("rst_gate", 0, 1'b1, 20);
      repeat (100) tick();
      #3;
      rst = 1'b1;
      #1;
      check("midrst_freq", 64'(freq), 0);
      check("midrst_freq_en", 64'(freq_en), 0);
      check("midrst_busy", 64'(busy), 0);
      check("midrst_overflow", 64'(overflow), 0);
      run      = 1'b0;
      async_en = 1'b0;
      tick();
      rst = 1'b0;
      repeat (5) tick();
      check("postrst_idle", 64'(busy | freq_en), 0);
      check("postrst_freq", 64'(freq), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
